// File: rtl/tv_pkg.sv
// Shared types for the test-vector runner: sequencer states and run modes.
package tv_pkg;
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

    localparam logic MODE_EXHAUSTIVE = 1'b0;
    localparam logic MODE_MEMORY     = 1'b1;
endpackage

// File: rtl/tv_mem.sv
// Vector store: one synchronous write port, one combinational read port.
// Contents are deliberately left unreset so vectors survive a run abort.
module tv_mem #(
    parameter  int IN_W  = 4,
    parameter  int OUT_W = 1,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [IN_W-1:0]  wr_stim_i,
    input  logic [OUT_W-1:0] wr_exp_i,
    input  logic [OUT_W-1:0] wr_mask_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [IN_W-1:0]  rd_stim_o,
    output logic [OUT_W-1:0] rd_exp_o,
    output logic [OUT_W-1:0] rd_mask_o
);
    logic [IN_W-1:0]  stim_q [DEPTH];
    logic [OUT_W-1:0] exp_q  [DEPTH];
    logic [OUT_W-1:0] mask_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            stim_q[wr_addr_i] <= wr_stim_i;
            exp_q[wr_addr_i]  <= wr_exp_i;
            mask_q[wr_addr_i] <= wr_mask_i;
        end
    end

    assign rd_stim_o = stim_q[rd_addr_i];
    assign rd_exp_o  = exp_q[rd_addr_i];
    assign rd_mask_o = mask_q[rd_addr_i];
endmodule

// File: rtl/tv_runner.sv
// Test-vector sequencer: applies stimulus, waits, compares masked DUT output,
// and tracks error count plus the first failing vector index.
//
//   state  | meaning
//   IDLE   | waiting for start after reset
//   APPLY  | drive stimulus of current vector onto dut_in
//   SETTLE | count down SETTLE_CYC cycles for the DUT to respond
//   CHECK  | compare masked response, advance or finish
//   DONE   | results held until the next start
module tv_runner
    import tv_pkg::*;
#(
    parameter  int IN_W       = 4,
    parameter  int OUT_W      = 1,
    parameter  int DEPTH      = 16,
    parameter  int SETTLE_CYC = 1,
    parameter  int ERR_W      = 16,
    localparam int AW         = $clog2(DEPTH),
    localparam int NV_W       = AW + 1,
    localparam int IDX_W      = (AW > IN_W) ? AW : IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [NV_W-1:0]  num_vec,
    input  logic             tv_wr_en,
    input  logic [AW-1:0]    tv_wr_addr,
    input  logic [IN_W-1:0]  tv_wr_stim,
    input  logic [OUT_W-1:0] tv_wr_exp,
    input  logic [OUT_W-1:0] tv_wr_mask,
    input  logic [OUT_W-1:0] ref_out,
    input  logic [OUT_W-1:0] dut_out,
    output logic [IN_W-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic [IDX_W-1:0] vec_idx
);
    localparam logic [3:0] SETTLE_LD = 4'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    state_t           state_q;
    logic             mode_q;
    logic [IDX_W:0]   total_q;
    logic [3:0]       settle_q;
    logic [IN_W-1:0]  dut_in_q;
    logic             busy_q, done_q, pass_q;
    logic [ERR_W-1:0] err_q;
    logic [IDX_W-1:0] ff_q, vec_q;

    logic [IN_W-1:0]  mem_stim;
    logic [OUT_W-1:0] mem_exp, mem_mask;
    logic [IN_W-1:0]  stim_sel;
    logic [OUT_W-1:0] exp_sel, mask_sel;
    logic [IDX_W:0]   start_total;
    logic             mismatch, last_vec;

    tv_mem #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) u_mem (
        .clk       (clk),
        .wr_en_i   (tv_wr_en && !busy_q),
        .wr_addr_i (tv_wr_addr),
        .wr_stim_i (tv_wr_stim),
        .wr_exp_i  (tv_wr_exp),
        .wr_mask_i (tv_wr_mask),
        .rd_addr_i (vec_q[AW-1:0]),
        .rd_stim_o (mem_stim),
        .rd_exp_o  (mem_exp),
        .rd_mask_o (mem_mask)
    );

    always_comb begin
        stim_sel = (mode_q == MODE_MEMORY) ? mem_stim : vec_q[IN_W-1:0];
        exp_sel  = (mode_q == MODE_MEMORY) ? mem_exp  : ref_out;
        mask_sel = (mode_q == MODE_MEMORY) ? mem_mask : '1;
        start_total = (IDX_W + 1)'(1) << IN_W;
        if (mode == MODE_MEMORY)
            start_total = (num_vec > NV_W'(DEPTH)) ? (IDX_W + 1)'(DEPTH) : (IDX_W + 1)'(num_vec);
        // Case-inequality so an X/Z on a compared bit counts as a failure.
        mismatch = ((dut_out & mask_sel) !== (exp_sel & mask_sel));
        last_vec = ({1'b0, vec_q} + (IDX_W + 1)'(1)) == total_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= MODE_EXHAUSTIVE;
            total_q  <= '0;
            settle_q <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ff_q     <= '0;
            vec_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0);
                    end
                    if (start) begin
                        err_q   <= '0;
                        ff_q    <= '0;
                        vec_q   <= '0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        mode_q  <= mode;
                        total_q <= start_total;
                        state_q <= (start_total == '0) ? DONE : APPLY;
                    end
                end
                APPLY: begin
                    dut_in_q <= stim_sel;
                    if (SETTLE_CYC == 0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= SETTLE_LD;
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == '0) state_q <= CHECK;
                    else                settle_q <= settle_q - 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_q != '1) err_q <= err_q + ERR_W'(1);
                        if (err_q == '0) ff_q <= vec_q;
                    end
                    if (last_vec) begin
                        state_q <= DONE;
                    end else begin
                        vec_q   <= vec_q + IDX_W'(1);
                        state_q <= APPLY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dut_in         = dut_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_idx = ff_q;
    assign vec_idx        = vec_q;
endmodule

// File: tb/tb_tv_runner.sv
// Bench for tv_runner: a 2:1 mux stands in for the course DUT; memory-mode
// runs are table driven, exhaustive/saturation/abort cases are hand sequences.
module tb_tv_runner;
    typedef struct {
        int nv;
        int inv_idx;
        bit mask_off;
        bit chk_din0;
        int exp_err;
        bit exp_pass;
        int exp_ff;
        int exp_lat;
        int exp_last;
    } row_t;

    typedef struct {
        int err;
        bit pass;
        int ff;
        int lat;
        int last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        mode = 1'b0;
    logic [4:0]  num_vec = '0;
    logic        tv_wr_en = 1'b0;
    logic [3:0]  tv_wr_addr = '0;
    logic [3:0]  tv_wr_stim = '0;
    logic        tv_wr_exp = 1'b0;
    logic        tv_wr_mask = 1'b0;
    logic        inv_ref = 1'b0;

    logic [3:0]  dut_in0, dut_in1;
    logic        dut_out0, dut_out1, ref_out0, ref_out1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] err0;
    logic [1:0]  err1;
    logic [3:0]  ff0, ff1, vec0, vec1;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    row_t rows[7];

    always #5 clk = ~clk;

    function automatic logic mux(input logic [3:0] s);
        return s[2] ? s[1] : s[0];
    endfunction

    assign dut_out0 = mux(dut_in0);
    assign ref_out0 = inv_ref ? ~dut_out0 : dut_out0;
    assign dut_out1 = mux(dut_in1);
    assign ref_out1 = ~dut_out1;

    tv_runner u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode), .num_vec(num_vec),
        .tv_wr_en(tv_wr_en), .tv_wr_addr(tv_wr_addr), .tv_wr_stim(tv_wr_stim),
        .tv_wr_exp(tv_wr_exp), .tv_wr_mask(tv_wr_mask),
        .ref_out(ref_out0), .dut_out(dut_out0), .dut_in(dut_in0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_idx(ff0), .vec_idx(vec0)
    );

    tv_runner #(.ERR_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .num_vec(num_vec),
        .tv_wr_en(tv_wr_en), .tv_wr_addr(tv_wr_addr), .tv_wr_stim(tv_wr_stim),
        .tv_wr_exp(tv_wr_exp), .tv_wr_mask(tv_wr_mask),
        .ref_out(ref_out1), .dut_out(dut_out1), .dut_in(dut_in1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_idx(ff1), .vec_idx(vec1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input int inv_idx, input bit mask_off);
        for (int i = 0; i < 16; i++) begin
            tv_wr_en   = 1'b1;
            tv_wr_addr = 4'(i);
            tv_wr_stim = 4'(i);
            tv_wr_exp  = mux(4'(i)) ^ (i == inv_idx);
            tv_wr_mask = !(mask_off && i == inv_idx);
            @(negedge clk);
        end
        tv_wr_en = 1'b0;
    endtask

    task automatic check_result0(input string tag, input int lat);
        exp_t e;
        e = sb.pop_front();
        chk({tag, " latency"}, lat, e.lat);
        chk({tag, " done"}, int'(done0), 1);
        chk({tag, " busy"}, int'(busy0), 0);
        chk({tag, " pass"}, int'(pass0), int'(e.pass));
        chk({tag, " err_count"}, int'(err0), e.err);
        chk({tag, " first_fail"}, int'(ff0), e.ff);
        chk({tag, " vec_idx"}, int'(vec0), e.last);
    endtask

    task automatic run_row(input int r);
        int n;
        load_mem(rows[r].inv_idx, rows[r].mask_off);
        sb.push_back('{err: rows[r].exp_err, pass: rows[r].exp_pass, ff: rows[r].exp_ff,
                       lat: rows[r].exp_lat, last: rows[r].exp_last});
        mode = 1'b1;
        num_vec = 5'(rows[r].nv);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_result0($sformatf("row%0d", r), n);
        if (rows[r].chk_din0) chk("nv0 dut_in", int'(dut_in0), 0);
    endtask

    initial begin
        int n;
        exp_t e;

        rows[0] = '{nv: 0,  inv_idx: -1, mask_off: 0, chk_din0: 1, exp_err: 0, exp_pass: 1, exp_ff: 0,  exp_lat: 1,  exp_last: 0};
        rows[1] = '{nv: 4,  inv_idx: 2,  mask_off: 0, chk_din0: 0, exp_err: 1, exp_pass: 0, exp_ff: 2,  exp_lat: 13, exp_last: 3};
        rows[2] = '{nv: 4,  inv_idx: 2,  mask_off: 1, chk_din0: 0, exp_err: 0, exp_pass: 1, exp_ff: 0,  exp_lat: 13, exp_last: 3};
        rows[3] = '{nv: 20, inv_idx: 2,  mask_off: 0, chk_din0: 0, exp_err: 1, exp_pass: 0, exp_ff: 2,  exp_lat: 49, exp_last: 15};
        rows[4] = '{nv: 1,  inv_idx: 0,  mask_off: 0, chk_din0: 0, exp_err: 1, exp_pass: 0, exp_ff: 0,  exp_lat: 4,  exp_last: 0};
        rows[5] = '{nv: 16, inv_idx: 13, mask_off: 0, chk_din0: 0, exp_err: 1, exp_pass: 0, exp_ff: 13, exp_lat: 49, exp_last: 15};
        rows[6] = '{nv: 16, inv_idx: -1, mask_off: 0, chk_din0: 0, exp_err: 0, exp_pass: 1, exp_ff: 0,  exp_lat: 49, exp_last: 15};

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy0), 0);
        chk("reset done", int'(done0), 0);
        chk("reset pass", int'(pass0), 0);
        chk("reset dut_in", int'(dut_in0), 0);
        chk("reset err_count", int'(err0), 0);
        chk("reset vec_idx", int'(vec0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 7; r++) run_row(r);

        // Exhaustive sweep with golden model equal to DUT: walk of dut_in.
        sb.push_back('{err: 0, pass: 1, ff: 0, lat: 49, last: 15});
        mode = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk);
            n++;
            if (n % 3 == 1 && n / 3 < 16) begin
                chk($sformatf("walk dut_in[%0d]", n / 3), int'(dut_in0), n / 3);
                chk($sformatf("walk vec_idx[%0d]", n / 3), int'(vec0), n / 3);
            end
        end
        check_result0("exhaustive", n);

        // Saturating counter with golden model always disagreeing.
        mode = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sat latency", n, 49);
        chk("sat err_count", int'(err1), 3);
        chk("sat first_fail", int'(ff1), 0);
        chk("sat pass", int'(pass1), 0);
        chk("sat done", int'(done1), 1);

        // Abort during CHECK of vector 5.
        inv_ref = 1'b1;
        mode = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (n < 17) begin
            @(negedge clk);
            n++;
        end
        chk("pre-abort err_count", int'(err0), 5);
        chk("pre-abort vec_idx", int'(vec0), 5);
        chk("pre-abort dut_in", int'(dut_in0), 5);
        rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy0), 0);
        chk("abort done", int'(done0), 0);
        chk("abort pass", int'(pass0), 0);
        chk("abort dut_in", int'(dut_in0), 0);
        chk("abort err_count", int'(err0), 0);
        chk("abort first_fail", int'(ff0), 0);
        chk("abort vec_idx", int'(vec0), 0);
        inv_ref = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh run: a write and a second start while busy must both be ignored.
        load_mem(-1, 1'b0);
        sb.push_back('{err: 0, pass: 1, ff: 0, lat: 13, last: 3});
        mode = 1'b1;
        num_vec = 5'd4;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 200) begin
            if (n == 3) begin
                tv_wr_en   = 1'b1;
                tv_wr_addr = 4'd1;
                tv_wr_stim = 4'd1;
                tv_wr_exp  = ~mux(4'd1);
                tv_wr_mask = 1'b1;
            end else if (n == 5) begin
                start0 = 1'b1;
            end
            @(negedge clk);
            n++;
            tv_wr_en = 1'b0;
            start0 = 1'b0;
        end
        check_result0("rerun", n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tv_runner.md
Name: tv_runner

Overview:
- Synthesizable, parametrised test-vector sequencer for course DUTs; the next generation of the hand-written stimulus/monitor bench.
- Drives a DUT input bus, waits a programmable settle time, then compares the DUT output against an expected value under a mask.
- Tracks the error count and the first failing index.
- Two modes: exhaustive sweep against a golden-model output, or replay from a loadable vector memory.

Parameters:
- IN_W, 4, DUT input width (1..16).
- OUT_W, 1, DUT output width (1..32).
- DEPTH, 16, vector memory entries (power of 2).
- SETTLE_CYC, 1, cycles between apply and compare (0..15).
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts a run.
- mode  in  1  0 = exhaustive, 1 = memory; sampled at start.
- num_vec  in  $clog2(DEPTH)+1  vectors to run in memory mode; sampled at start.
- tv_wr_en  in  1  vector memory write strobe.
- tv_wr_addr  in  $clog2(DEPTH)  write address.
- tv_wr_stim  in  IN_W  stimulus word.
- tv_wr_exp  in  OUT_W  expected output.
- tv_wr_mask  in  OUT_W  1 = compare this bit.
- ref_out  in  OUT_W  golden-model output (exhaustive mode).
- dut_out  in  OUT_W  DUT response.
- dut_in  out  IN_W  registered stimulus to DUT.
- busy  out  1  run in progress.
- done  out  1  level; run finished.
- pass  out  1  valid with done; 1 iff err_count==0.
- err_count  out  ERR_W  saturating mismatch count.
- first_fail_idx  out  $clog2(DEPTH) max IN_W  index of first mismatch.
- vec_idx  out  same  current vector index.

Behaviour:
- Reset (async, rst_n=0): state IDLE. dut_in, busy, done, pass, err_count, first_fail_idx, vec_idx all 0. Vector memory contents are not reset.
- Vector memory: synchronous write on tv_wr_en when not busy; writes while busy are ignored. Read is combinational.
- FSM: IDLE -> APPLY -> SETTLE -> CHECK -> (APPLY | DONE).
  - IDLE/DONE + start: clear err_count, first_fail_idx, vec_idx and done; latch mode and num_vec; set busy. Go to APPLY, or straight to DONE if the vector total is 0.
  - APPLY (1 cycle): dut_in <= stim(vec_idx). Stim is vec_idx[IN_W-1:0] in exhaustive mode, mem[vec_idx].stim in memory mode.
  - SETTLE: waits SETTLE_CYC cycles; skipped when SETTLE_CYC=0.
  - CHECK (1 cycle): expected and mask are ref_out and all-ones in exhaustive mode, mem entry in memory mode.
    - Mismatch iff any masked bit differs, or a masked dut_out bit is X/Z (case-inequality in sim).
    - On mismatch: err_count++ (saturates at 2^ERR_W-1); if err_count was 0, first_fail_idx <= vec_idx.
    - Last vector: go to DONE. Otherwise vec_idx++ and go to APPLY.
  - DONE: busy=0, done=1, pass=(err_count==0); outputs held until next start or reset.
- Vector total: 2^IN_W in exhaustive mode; min(num_vec, DEPTH) in memory mode.
- Per-vector cost: SETTLE_CYC+2 cycles. done rises N*(SETTLE_CYC+2)+1 cycles after start is sampled.
- start while busy is ignored. mode, num_vec and ref_out are only meaningful at their sample points.
- vec_idx does not wrap; the final index is total-1.
- Reset mid-run aborts immediately to the reset values.

Decomposition:
- tv_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, APPLY, SETTLE, CHECK, DONE};
  - MODE_EXHAUSTIVE = 1'b0 and MODE_MEMORY = 1'b1.
- Sub-module tv_mem, parametrised IN_W/OUT_W/DEPTH: stores {stim, exp, mask}; 1 write port, 1 async read port.

Test Plan:
- Exhaustive, IN_W=4, SETTLE_CYC=1, ref_out wired to dut_out -> dut_in walks 0..15; done rises 49 cycles after start; pass=1, err_count=0.
- Memory mode, 2:1 mux DUT, 4 vectors, entry 2 exp inverted -> err_count=1, first_fail_idx=2, pass=0.
- Same run with mask=0 on entry 2 -> pass=1, err_count=0.
- num_vec=0 -> done=1 one cycle after start, pass=1, dut_in stays 0.
- Exhaustive, ERR_W=2, ref_out=~dut_out -> 16 mismatches, err_count=3 (saturated), first_fail_idx=0.
- rst_n low during CHECK of vector 5 -> all outputs 0 asynchronously.
  - A tv_wr_en during busy is dropped.
  - A fresh start after release reruns cleanly, and a second start while busy is ignored.
